// File: rtl/img2col_map_seq.sv
// rtl/img2col_map_seq.sv - img2col mapping sequencer: row/PU/address index generator for the PU array
//
// Two phases per mapping: a buffering pre-load of KSIZE-1 image rows spread over
// all PUs, then NUM_ROUNDS rounds.  In each round every PU receives KSIZE addresses
// for the newest row. The sequencer then waits for that PU's done flag before it
// moves on to the next PU.
//
// Ports:
//   clk, nrst    clock, asynchronous active-low reset
//   start        begin mapping (only honoured in IDLE)
//   stop         synchronous abort back to IDLE (highest priority)
//   pu_done      per-PU done level, only the selected PU's bit is looked at
//   busy         high in every non-IDLE state
//   addr_vld     pu_addr/pu_sel/row_sel valid this cycle
//   pu_addr      address within PU, 0..KSIZE-1
//   pu_sel       target PU, 0..NUM_PU-1
//   row_sel      image row being mapped
//   round        current output round, 0..NUM_ROUNDS-1
//   act          one-cycle pulse on the first address of every round
//   map_finish   one-cycle pulse on completion
//   stall_cnt    (only with IMG2COL_MAP_STALL_CNT_EN) saturating count of
//                wait cycles spent with the selected PU not done
//
// Optional feature macro: IMG2COL_MAP_STALL_CNT_EN

module img2col_map_seq #(
  parameter int NUM_PU   = 28,
  parameter int KSIZE    = 5,
  parameter int IMG_ROWS = 28,
  parameter int CW       = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_PU-1:0] pu_done,
  output logic              busy,
  output logic              addr_vld,
  output logic [CW-1:0]     pu_addr,
  output logic [CW-1:0]     pu_sel,
  output logic [CW-1:0]     row_sel,
  output logic [CW-1:0]     round,
  output logic              act,
  output logic              map_finish
`ifdef IMG2COL_MAP_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int NUM_ROUNDS = IMG_ROWS - KSIZE + 1;

  localparam logic [CW-1:0] ADDR_LAST    = CW'(KSIZE - 1);
  localparam logic [CW-1:0] PU_LAST      = CW'(NUM_PU - 1);
  localparam logic [CW-1:0] BUF_ROW_LAST = CW'(KSIZE - 2);
  localparam logic [CW-1:0] ROUND_LAST   = CW'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0] W_ROW_FIRST  = CW'(KSIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUFFER,
    W_ADDR,
    W_WAIT,
    DONE
  } state_t;

  state_t          state, state_n;
  logic            busy_n, addr_vld_n, act_n, map_finish_n;
  logic [CW-1:0]   pu_addr_n, pu_sel_n, row_sel_n, round_n;
  logic            sel_done;
  logic            start_acc;

  // Done flag of the currently selected PU; a compare loop keeps the
  // select index width independent of NUM_PU.
  always_comb begin
    sel_done = 1'b0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (pu_sel == CW'(i)) sel_done = pu_done[i];
    end
  end

  assign start_acc = (state == IDLE) && start && !stop;

  always_comb begin
    state_n      = state;
    busy_n       = busy;
    addr_vld_n   = addr_vld;
    pu_addr_n    = pu_addr;
    pu_sel_n     = pu_sel;
    row_sel_n    = row_sel;
    round_n      = round;
    act_n        = 1'b0;
    map_finish_n = 1'b0;

    case (state)
      IDLE: begin
        if (start_acc) begin
          state_n    = BUFFER;
          busy_n     = 1'b1;
          addr_vld_n = 1'b1;
          pu_addr_n  = '0;
          pu_sel_n   = '0;
          row_sel_n  = '0;
          round_n    = '0;
        end
      end

      BUFFER: begin
        if (pu_addr == ADDR_LAST) begin
          pu_addr_n = '0;
          if (pu_sel == PU_LAST) begin
            pu_sel_n = '0;
            if (row_sel == BUF_ROW_LAST) begin
              // Pre-load complete: round 0 maps the first row not yet buffered.
              state_n   = W_ADDR;
              row_sel_n = W_ROW_FIRST;
              round_n   = '0;
              act_n     = 1'b1;
            end else begin
              row_sel_n = row_sel + 1'b1;
            end
          end else begin
            pu_sel_n = pu_sel + 1'b1;
          end
        end else begin
          pu_addr_n = pu_addr + 1'b1;
        end
      end

      W_ADDR: begin
        if (pu_addr == ADDR_LAST) begin
          state_n    = W_WAIT;
          addr_vld_n = 1'b0;
        end else begin
          pu_addr_n = pu_addr + 1'b1;
        end
      end

      W_WAIT: begin
        if (sel_done) begin
          if (pu_sel != PU_LAST) begin
            state_n    = W_ADDR;
            addr_vld_n = 1'b1;
            pu_sel_n   = pu_sel + 1'b1;
            pu_addr_n  = '0;
          end else if (round != ROUND_LAST) begin
            // row_sel tracks round + KSIZE-1, so both advance together.
            state_n    = W_ADDR;
            addr_vld_n = 1'b1;
            round_n    = round + 1'b1;
            row_sel_n  = row_sel + 1'b1;
            pu_sel_n   = '0;
            pu_addr_n  = '0;
            act_n      = 1'b1;
          end else begin
            state_n      = DONE;
            map_finish_n = 1'b1;
          end
        end
      end

      DONE: begin
        state_n    = IDLE;
        busy_n     = 1'b0;
        addr_vld_n = 1'b0;
        pu_addr_n  = '0;
        pu_sel_n   = '0;
        row_sel_n  = '0;
        round_n    = '0;
      end

      default: begin
        state_n    = IDLE;
        busy_n     = 1'b0;
        addr_vld_n = 1'b0;
        pu_addr_n  = '0;
        pu_sel_n   = '0;
        row_sel_n  = '0;
        round_n    = '0;
      end
    endcase

    // Abort overrides every other transition and suppresses map_finish.
    if (stop && (state != IDLE)) begin
      state_n      = IDLE;
      busy_n       = 1'b0;
      addr_vld_n   = 1'b0;
      pu_addr_n    = '0;
      pu_sel_n     = '0;
      row_sel_n    = '0;
      round_n      = '0;
      act_n        = 1'b0;
      map_finish_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      addr_vld   <= 1'b0;
      pu_addr    <= '0;
      pu_sel     <= '0;
      row_sel    <= '0;
      round      <= '0;
      act        <= 1'b0;
      map_finish <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= busy_n;
      addr_vld   <= addr_vld_n;
      pu_addr    <= pu_addr_n;
      pu_sel     <= pu_sel_n;
      row_sel    <= row_sel_n;
      round      <= round_n;
      act        <= act_n;
      map_finish <= map_finish_n;
    end
  end

`ifdef IMG2COL_MAP_STALL_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state == W_WAIT) && !sel_done && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/img2col_map_seq.md
Name: img2col_map_seq

Overview:
Parametrised img2col mapping sequencer for the CNN accelerator. It generates row, processing-unit (PU) and PU-address indices that steer image pixels into the PU array. Operation has two phases: a buffering pre-load of KSIZE-1 rows, then per-round streaming with an explicit PU-done handshake. Sits between the line buffer and the PU array; replaces fixed 28-PU/5x5 sequencing with a fully synchronous, parametrised controller.

Parameters:
NUM_PU, 28, number of processing units, >=2
KSIZE, 5, kernel height/width, >=2
IMG_ROWS, 28, input image rows, >KSIZE
CW, 6, index/counter width; all indices must fit
(localparam NUM_ROUNDS = IMG_ROWS-KSIZE+1)

Ports:
clk  in  1  clock
nrst  in  1  async active-low reset
start  in  1  begin mapping; sampled only in IDLE
stop  in  1  sync abort; returns to IDLE
pu_done  in  NUM_PU  per-PU done flag (level)
busy  out  1  high in any non-IDLE state
addr_vld  out  1  pu_addr/pu_sel/row_sel valid this cycle
pu_addr  out  CW  address within PU, 0..KSIZE-1
pu_sel  out  CW  target PU, 0..NUM_PU-1
row_sel  out  CW  image row being mapped
round  out  CW  current output round, 0..NUM_ROUNDS-1
act  out  1  1-cycle pulse at start of each round
map_finish  out  1  1-cycle pulse on completion

Behaviour:
- Reset: nrst asynchronous, active-low; clock clk. Reset drives state=IDLE and all outputs to 0. All outputs are registered; no other async events.
- States: IDLE, BUFFER, W_ADDR, W_WAIT, DONE.
- IDLE: outputs 0. start=1 -> BUFFER next cycle. start in any other state is ignored.
- BUFFER: addr_vld=1, one index per cycle; pu_addr increments 0..KSIZE-1. Wrap -> pu_sel++. pu_sel wrap at NUM_PU-1 -> row_sel++. After row KSIZE-2, PU NUM_PU-1, addr KSIZE-1 -> W_ADDR. Length is exactly (KSIZE-1)*NUM_PU*KSIZE cycles.
- W_ADDR: addr_vld=1; row_sel=round+KSIZE-1; pu_addr 0..KSIZE-1, one per cycle, then -> W_WAIT.
- W_WAIT: addr_vld=0; indices hold, with pu_addr=KSIZE-1.
  - pu_done[pu_sel] sampled each cycle. When 1:
    - pu_sel<NUM_PU-1: pu_sel++, pu_addr=0, -> W_ADDR.
    - pu_sel=NUM_PU-1 and round<NUM_ROUNDS-1: round++, pu_sel=0, -> W_ADDR.
    - Last PU of last round: -> DONE.
  - Minimum per PU is KSIZE+1 cycles; each cycle pu_done is low adds one stall cycle.
- act: high for exactly the first W_ADDR cycle of every round, including round 0, coincident with the updated round value.
- DONE: map_finish=1 for one cycle, busy=1; -> IDLE next cycle.
- stop=1 in any non-IDLE state: -> IDLE next cycle, outputs 0, no map_finish. stop has priority over every other transition. stop in IDLE is a no-op; stop and start together in IDLE -> remain IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0.
- pu_done for non-selected PUs is ignored. Counters never exceed their ranges; no modulo arithmetic wraps beyond the parameter limits.

Optional Feature:
Macro IMG2COL_MAP_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], counting W_WAIT cycles with pu_done[pu_sel]=0. Cleared on reset and on start acceptance; saturates at all-ones; holds after DONE/stop.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
(Bench parameters NUM_PU=2, KSIZE=3, IMG_ROWS=5 -> NUM_ROUNDS=3.)
1. Reset then start pulse, pu_done tied 1 -> BUFFER lasts 12 cycles (row_sel 0..1, pu_sel 0..1, pu_addr 0..2). First W_ADDR shows round=0, row_sel=2, act=1.
2. Same run to completion -> each PU takes 4 cycles; act pulses at rounds 0,1,2 with row_sel 2,3,4. map_finish is a single pulse 12+24=36 cycles after BUFFER entry, then busy=0.
3. Hold pu_done[1]=0 for 5 cycles in round 1, PU 1 -> indices hold with addr_vld=0 for 5 extra cycles. pu_done[0]=1 during this window is ignored. With macro defined, stall_cnt=5.
4. stop asserted in W_ADDR of round 1 -> next cycle IDLE, all outputs 0, no map_finish. A new start restarts from BUFFER row 0.
5. start asserted during BUFFER and W_WAIT -> no effect. nrst pulled low mid-BUFFER -> outputs 0 immediately, asynchronously.
6. Default parameters (28/5/28), pu_done tied 1 -> BUFFER 560 cycles, 24 rounds, 24 act pulses, final round=23, final row_sel=27.
